// File: rtl/snake_head_stepper_pkg.sv
// Shared encodings and helpers for the snake head stepper and its direction queue.
package snake_head_stepper_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam logic [1:0] SPEED_SLOW = 2'd0;
  localparam logic [1:0] SPEED_HALF = 2'd1;
  localparam logic [1:0] SPEED_FAST = 2'd2;

  typedef enum logic [1:0] {
    WAIT_START = 2'd0,
    RUN        = 2'd1,
    OVER       = 2'd2
  } state_t;

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Request bits are {up, down, left, right}; only meaningful when one-hot.
  function automatic logic [1:0] onehot_to_dir(input logic [3:0] v);
    logic [1:0] d;
    d = DIR_RIGHT;
    if (v[3]) d = DIR_UP;
    else if (v[2]) d = DIR_DOWN;
    else if (v[1]) d = DIR_LEFT;
    return d;
  endfunction

  function automatic logic [1:0] opposite(input logic [1:0] d);
    return {d[1], ~d[0]};
  endfunction

endpackage

// File: rtl/snake_head_stepper_if.sv
// Player direction request channel into the snake head stepper.
interface snake_head_stepper_if;
  logic [3:0] dir_req;
  logic       dir_req_valid;

  modport master (output dir_req, output dir_req_valid);
  modport slave  (input dir_req, input dir_req_valid);
endinterface

// File: rtl/snake_head_stepper_dir_queue.sv
// Two-entry FIFO of pending headings; drops duplicates, reversals and malformed requests.
module snake_head_stepper_dir_queue
  import snake_head_stepper_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       push_en,
  input  logic       filter_en,
  input  logic       req_valid,
  input  logic [3:0] req,
  input  logic       pop,
  input  logic [1:0] ref_dir,
  input  logic       has_space,
  output logic [1:0] head,
  output logic [1:0] tail,
  output logic       empty,
  output logic       full,
  output logic       push
);

  logic [1:0] mem [2];
  logic [1:0] count;
  logic [1:0] count_after_pop;
  logic [1:0] req_dir;
  logic       do_pop;

  assign empty           = (count == 2'd0);
  assign full            = (count == 2'd2);
  assign head            = mem[0];
  assign tail            = full ? mem[1] : mem[0];
  assign do_pop          = pop && !empty;
  assign count_after_pop = count - {1'b0, do_pop};
  assign req_dir         = onehot_to_dir(req);

  assign push = push_en && req_valid && is_onehot(req) && has_space &&
                (!filter_en || ((req_dir != ref_dir) && (req_dir != opposite(ref_dir))));

  // A push landing in slot 0 during a pop must win over the shift, so it comes last.
  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= 2'd0;
      mem[0] <= DIR_RIGHT;
      mem[1] <= DIR_RIGHT;
    end else begin
      if (do_pop) mem[0] <= mem[1];
      if (push) mem[count_after_pop[0]] <= req_dir;
      count <= count_after_pop + {1'b0, push};
    end
  end

endmodule

// File: rtl/snake_head_stepper.sv
// Advances the snake head one cell per selected speed tick and ends the game on collisions.
module snake_head_stepper
  import snake_head_stepper_pkg::*;
#(
  parameter int GRID_W  = 32,
  parameter int GRID_H  = 24,
  parameter int X_W     = 5,
  parameter int Y_W     = 5,
  parameter int START_X = 16,
  parameter int START_Y = 12,
  parameter int WRAP    = 0
) (
  input  logic                 clk50,
  input  logic                 reset,
  input  logic                 tick_slow,
  input  logic                 tick_half,
  input  logic                 tick_fast,
  input  logic [1:0]           speed_sel,
  snake_head_stepper_if.slave  req_bus,
  input  logic                 pause,
  input  logic                 self_hit,
  output logic [X_W-1:0]       head_x,
  output logic [Y_W-1:0]       head_y,
  output logic [1:0]           dir,
  output logic                 step,
  output logic                 gameOver
);

  state_t         state, state_next;
  logic [X_W-1:0] x_next, x_moved;
  logic [Y_W-1:0] y_next, y_moved;
  logic [1:0]     dir_next, new_dir, q_head, q_tail, ref_dir;
  logic           step_next, sel_tick, do_step, pop, push;
  logic           q_empty, q_full, at_edge;

  always_comb begin
    case (speed_sel)
      SPEED_SLOW: sel_tick = tick_slow;
      SPEED_HALF: sel_tick = tick_half;
      default:    sel_tick = tick_fast;
    endcase
  end

  assign do_step  = (state == RUN) && !pause && sel_tick;
  assign pop      = do_step && !q_empty;
  assign new_dir  = pop ? q_head : dir;
  assign ref_dir  = q_empty ? dir : q_tail;
  assign gameOver = (state == OVER);

  // Before the game starts there is no heading to reverse, so any clean request may start it.
  snake_head_stepper_dir_queue u_queue (
    .clk       (clk50),
    .reset     (reset),
    .push_en   (state != OVER),
    .filter_en (state == RUN),
    .req_valid (req_bus.dir_req_valid),
    .req       (req_bus.dir_req),
    .pop       (pop),
    .ref_dir   (ref_dir),
    .has_space (!q_full || pop),
    .head      (q_head),
    .tail      (q_tail),
    .empty     (q_empty),
    .full      (q_full),
    .push      (push)
  );

  always_comb begin
    x_moved = head_x;
    y_moved = head_y;
    at_edge = 1'b0;
    case (new_dir)
      DIR_UP: begin
        at_edge = (head_y == '0);
        y_moved = at_edge ? Y_W'(GRID_H - 1) : head_y - Y_W'(1);
      end
      DIR_DOWN: begin
        at_edge = (head_y == Y_W'(GRID_H - 1));
        y_moved = at_edge ? '0 : head_y + Y_W'(1);
      end
      DIR_LEFT: begin
        at_edge = (head_x == '0);
        x_moved = at_edge ? X_W'(GRID_W - 1) : head_x - X_W'(1);
      end
      default: begin
        at_edge = (head_x == X_W'(GRID_W - 1));
        x_moved = at_edge ? '0 : head_x + X_W'(1);
      end
    endcase
  end

  always_comb begin
    state_next = state;
    x_next     = head_x;
    y_next     = head_y;
    dir_next   = dir;
    step_next  = 1'b0;
    case (state)
      WAIT_START: if (push) state_next = RUN;
      RUN: begin
        if (do_step) begin
          dir_next = new_dir;
          if (at_edge && (WRAP == 0)) begin
            state_next = OVER;
          end else begin
            x_next    = x_moved;
            y_next    = y_moved;
            step_next = 1'b1;
          end
        end
        if (self_hit) state_next = OVER;
      end
      OVER: state_next = OVER;
      default: state_next = WAIT_START;
    endcase
  end

  always_ff @(posedge clk50) begin
    if (reset) begin
      state  <= WAIT_START;
      head_x <= X_W'(START_X);
      head_y <= Y_W'(START_Y);
      dir    <= DIR_RIGHT;
      step   <= 1'b0;
    end else begin
      state  <= state_next;
      head_x <= x_next;
      head_y <= y_next;
      dir    <= dir_next;
      step   <= step_next;
    end
  end

endmodule
